ft232h_recv_cmd: RTL and testbench



---
 rtl/ft232h_recv_cmd.sv | 167 ++++++++++++++++
 tb/tb_ft232h_recv_cmd.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ft232h_recv_cmd.sv
// FT232H synchronous-FIFO receive path: owns the data bus on grant, reads host bytes and
// decodes SYNC/ADDR/DHI/DLO/CSUM frames into single-cycle register write strobes.
module ft232h_recv_cmd #(
   parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
   parameter int unsigned TIMEOUT_CYC = 6000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        rx_en_i,
   input  logic        ft_rxf_i,
   input  logic [7:0]  ft_adbus_i,
   output logic        ft_oe_o,
   output logic        ft_rd_o,
   output logic        rx_busy_o,
   output logic        reg_wr_o,
   output logic [7:0]  reg_addr_o,
   output logic [15:0] reg_data_o,
   output logic [7:0]  err_cnt_o,
   output logic [7:0]  drop_cnt_o
);

   typedef enum logic [1:0] {BusIdle, BusOeWait, BusRead} bus_state_e;
   typedef enum logic [2:0] {PrsSync, PrsAddr, PrsDhi, PrsDlo, PrsCsum} prs_state_e;

   localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYC - 1);

   bus_state_e  r_bus_state;
   prs_state_e  r_prs_state;
   logic        r_oe_n;
   logic        r_rd_n;
   logic        r_busy;
   logic        r_reg_wr;
   logic [7:0]  r_reg_addr;
   logic [15:0] r_reg_data;
   logic [7:0]  r_err_cnt;
   logic [7:0]  r_drop_cnt;
   logic [7:0]  r_addr;
   logic [7:0]  r_dhi;
   logic [7:0]  r_dlo;
   logic [15:0] r_idle_cnt;

   logic w_accept;
   logic w_csum_ok;
   logic w_timeout;
   logic w_err_inc;
   logic w_drop_inc;

   assign w_accept   = (r_bus_state == BusRead) && !r_rd_n && !ft_rxf_i && rx_en_i;
   assign w_csum_ok  = (ft_adbus_i == (r_addr ^ r_dhi ^ r_dlo));
   // An accepted byte always beats a coincident timeout.
   assign w_timeout  = (r_prs_state != PrsSync) && !w_accept && (r_idle_cnt == TimeoutLast);
   assign w_err_inc  = w_timeout || (w_accept && (r_prs_state == PrsCsum) && !w_csum_ok);
   assign w_drop_inc = w_accept && (r_prs_state == PrsSync) && (ft_adbus_i != SYNC_BYTE);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_bus_state <= BusIdle;
         r_oe_n      <= 1'b1;
         r_rd_n      <= 1'b1;
         r_busy      <= 1'b0;
      end else begin
         case (r_bus_state)
            BusIdle: begin
               if (rx_en_i && !ft_rxf_i) begin
                  r_bus_state <= BusOeWait;
                  r_oe_n      <= 1'b0;
                  r_busy      <= 1'b1;
               end
            end
            BusOeWait: begin
               if (!rx_en_i) begin
                  r_bus_state <= BusIdle;
                  r_oe_n      <= 1'b1;
                  r_rd_n      <= 1'b1;
                  r_busy      <= 1'b0;
               end else begin
                  r_bus_state <= BusRead;
                  r_rd_n      <= 1'b0;
               end
            end
            BusRead: begin
               if (ft_rxf_i || !rx_en_i) begin
                  r_bus_state <= BusIdle;
                  r_oe_n      <= 1'b1;
                  r_rd_n      <= 1'b1;
                  r_busy      <= 1'b0;
               end
            end
            default: begin
               r_bus_state <= BusIdle;
               r_oe_n      <= 1'b1;
               r_rd_n      <= 1'b1;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_prs_state <= PrsSync;
         r_reg_wr    <= 1'b0;
         r_reg_addr  <= '0;
         r_reg_data  <= '0;
         r_err_cnt   <= '0;
         r_drop_cnt  <= '0;
         r_addr      <= '0;
         r_dhi       <= '0;
         r_dlo       <= '0;
         r_idle_cnt  <= '0;
      end else begin
         r_reg_wr <= 1'b0;
         if (w_err_inc && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
         end
         if (w_drop_inc && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
         end
         if (w_accept) begin
            r_idle_cnt <= '0;
            case (r_prs_state)
               PrsSync: begin
                  if (ft_adbus_i == SYNC_BYTE) begin
                     r_prs_state <= PrsAddr;
                  end
               end
               PrsAddr: begin
                  r_addr      <= ft_adbus_i;
                  r_prs_state <= PrsDhi;
               end
               PrsDhi: begin
                  r_dhi       <= ft_adbus_i;
                  r_prs_state <= PrsDlo;
               end
               PrsDlo: begin
                  r_dlo       <= ft_adbus_i;
                  r_prs_state <= PrsCsum;
               end
               PrsCsum: begin
                  r_prs_state <= PrsSync;
                  if (w_csum_ok) begin
                     r_reg_wr   <= 1'b1;
                     r_reg_addr <= r_addr;
                     r_reg_data <= {r_dhi, r_dlo};
                  end
               end
               default: r_prs_state <= PrsSync;
            endcase
         end else if (w_timeout) begin
            r_prs_state <= PrsSync;
            r_idle_cnt  <= '0;
         end else if (r_prs_state != PrsSync) begin
            r_idle_cnt <= r_idle_cnt + 16'd1;
         end
      end
   end

   assign ft_oe_o    = r_oe_n;
   assign ft_rd_o    = r_rd_n;
   assign rx_busy_o  = r_busy;
   assign reg_wr_o   = r_reg_wr;
   assign reg_addr_o = r_reg_addr;
   assign reg_data_o = r_reg_data;
   assign err_cnt_o  = r_err_cnt;
   assign drop_cnt_o = r_drop_cnt;

endmodule

// File: tb/tb_ft232h_recv_cmd.sv
// Directed bench for ft232h_recv_cmd: a small FT232H FIFO model feeds byte queues and each
// scenario task checks bus handshake, decoded writes and error/drop counters inline.
module tb_ft232h_recv_cmd;

   localparam int TimeoutCyc = 6000;

   logic        clk = 1'b0;
   logic        rst;
   logic        rx_en;
   logic        rxf;
   logic [7:0]  adbus;
   logic        oe_n;
   logic        rd_n;
   logic        busy;
   logic        reg_wr;
   logic [7:0]  reg_addr;
   logic [15:0] reg_data;
   logic [7:0]  err_cnt;
   logic [7:0]  drop_cnt;

   ft232h_recv_cmd #(
      .SYNC_BYTE   (8'hA5),
      .TIMEOUT_CYC (TimeoutCyc)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .rx_en_i    (rx_en),
      .ft_rxf_i   (rxf),
      .ft_adbus_i (adbus),
      .ft_oe_o    (oe_n),
      .ft_rd_o    (rd_n),
      .rx_busy_o  (busy),
      .reg_wr_o   (reg_wr),
      .reg_addr_o (reg_addr),
      .reg_data_o (reg_data),
      .err_cnt_o  (err_cnt),
      .drop_cnt_o (drop_cnt)
   );

   always #5 clk = ~clk;

   logic [7:0]  q[$];
   int          n_checks = 0;
   int          n_fail = 0;
   int          tick_n = 0;
   int          acc_cnt = 0;
   int          last_acc_tick = 0;
   int          wr_cnt = 0;
   int          wr_tick = -1;
   logic [7:0]  wr_addr;
   logic [15:0] wr_data;
   int          oe_fall = -1;
   int          rd_fall = -1;
   int          rd_viol = 0;
   logic        prev_oe = 1'b1;
   logic        prev_rd = 1'b1;

   // One clock: FT model presents the queue head, pops it when RD# was low with data present.
   task automatic tick();
      logic pre_rd;
      @(negedge clk);
      rxf   = (q.size() == 0);
      adbus = (q.size() != 0) ? q[0] : 8'h00;
      pre_rd = rd_n;
      @(posedge clk);
      tick_n++;
      if (!rst && rx_en && !pre_rd && !rxf) begin
         void'(q.pop_front());
         acc_cnt++;
         last_acc_tick = tick_n;
      end
      #1;
      if (reg_wr) begin
         wr_cnt++;
         wr_addr = reg_addr;
         wr_data = reg_data;
         wr_tick = tick_n;
      end
      if (prev_oe && !oe_n) oe_fall = tick_n;
      if (prev_rd && !rd_n) rd_fall = tick_n;
      if ((rxf || !rx_en || rst) && !rd_n) rd_viol++;
      prev_oe = oe_n;
      prev_rd = rd_n;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 1000 && q.size() != 0; i++) tick();
      n_checks++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL %s_drain: %0d bytes left, want 0", name, q.size());
      end
      repeat (3) tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      rx_en = 1'b0;
      q.delete();
      repeat (2) tick();
      rst = 1'b0;
      rx_en = 1'b1;
      wr_cnt = 0;
      acc_cnt = 0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      rx_en = 1'b0;
      repeat (2) tick();
      n_checks++; if (oe_n !== 1'b1) begin n_fail++; $display("FAIL rst_oe: got %b want 1", oe_n); end
      n_checks++; if (rd_n !== 1'b1) begin n_fail++; $display("FAIL rst_rd: got %b want 1", rd_n); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
      n_checks++;
      if (reg_wr !== 1'b0) begin n_fail++; $display("FAIL rst_wr: got %b want 0", reg_wr); end
      n_checks++;
      if (reg_addr !== 8'h00) begin n_fail++; $display("FAIL rst_addr: got %h want 00", reg_addr); end
      n_checks++;
      if (reg_data !== 16'h0) begin n_fail++; $display("FAIL rst_data: got %h want 0000", reg_data); end
      n_checks++;
      if (err_cnt !== 8'h00) begin n_fail++; $display("FAIL rst_err: got %h want 00", err_cnt); end
      n_checks++;
      if (drop_cnt !== 8'h00) begin n_fail++; $display("FAIL rst_drop: got %h want 00", drop_cnt); end
      rst = 1'b0;
   endtask

   task automatic test_valid_frame();
      do_reset();
      q = {8'hA5, 8'h12, 8'h34, 8'h56, 8'h70};
      drain("valid");
      n_checks++;
      if (rd_fall - oe_fall != 1) begin
         n_fail++; $display("FAIL valid_oe_lead: got %0d cycles want 1", rd_fall - oe_fall);
      end
      n_checks++; if (wr_cnt != 1) begin n_fail++; $display("FAIL valid_wr: got %0d want 1", wr_cnt); end
      n_checks++;
      if (wr_tick != last_acc_tick) begin
         n_fail++; $display("FAIL valid_latency: got tick %0d want %0d", wr_tick, last_acc_tick);
      end
      n_checks++;
      if (wr_addr !== 8'h12) begin n_fail++; $display("FAIL valid_addr: got %h want 12", wr_addr); end
      n_checks++;
      if (wr_data !== 16'h3456) begin n_fail++; $display("FAIL valid_data: got %h want 3456", wr_data); end
      n_checks++;
      if (err_cnt !== 8'h00) begin n_fail++; $display("FAIL valid_err: got %h want 00", err_cnt); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL valid_busy: got %b want 0", busy); end
   endtask

   task automatic test_bad_csum();
      do_reset();
      q = {8'hA5, 8'h12, 8'h34, 8'h56, 8'h00};
      drain("badcs");
      n_checks++; if (wr_cnt != 0) begin n_fail++; $display("FAIL badcs_wr: got %0d want 0", wr_cnt); end
      n_checks++;
      if (err_cnt !== 8'h01) begin n_fail++; $display("FAIL badcs_err: got %h want 01", err_cnt); end
      n_checks++;
      if (reg_addr !== 8'h00) begin n_fail++; $display("FAIL badcs_addr: got %h want 00", reg_addr); end
      // Back in SYNC: a non-sync byte must be counted as dropped.
      q = {8'h11};
      drain("badcs_sync");
      n_checks++;
      if (drop_cnt !== 8'h01) begin n_fail++; $display("FAIL badcs_sync: got %h want 01", drop_cnt); end
   endtask

   task automatic test_hunt();
      do_reset();
      q = {8'h00, 8'hFF, 8'hA5, 8'h01, 8'h00, 8'h02, 8'h03};
      drain("hunt");
      n_checks++;
      if (drop_cnt !== 8'h02) begin n_fail++; $display("FAIL hunt_drop: got %h want 02", drop_cnt); end
      n_checks++; if (wr_cnt != 1) begin n_fail++; $display("FAIL hunt_wr: got %0d want 1", wr_cnt); end
      n_checks++;
      if (wr_addr !== 8'h01) begin n_fail++; $display("FAIL hunt_addr: got %h want 01", wr_addr); end
      n_checks++;
      if (wr_data !== 16'h0002) begin n_fail++; $display("FAIL hunt_data: got %h want 0002", wr_data); end
   endtask

   task automatic test_split_burst();
      int rd_low;
      do_reset();
      rd_low = 0;
      q = {8'hA5, 8'h12};
      for (int i = 0; i < 50 && q.size() != 0; i++) tick();
      for (int i = 0; i < 100; i++) begin
         tick();
         if (!rd_n) rd_low++;
      end
      n_checks++;
      if (rd_low != 0) begin n_fail++; $display("FAIL split_rd_gap: got %0d low cycles want 0", rd_low); end
      q = {8'h34, 8'h56, 8'h70};
      drain("split");
      n_checks++; if (wr_cnt != 1) begin n_fail++; $display("FAIL split_wr: got %0d want 1", wr_cnt); end
      n_checks++;
      if (wr_data !== 16'h3456) begin n_fail++; $display("FAIL split_data: got %h want 3456", wr_data); end
      n_checks++;
      if (err_cnt !== 8'h00) begin n_fail++; $display("FAIL split_err: got %h want 00", err_cnt); end
   endtask

   task automatic test_timeout();
      int t0;
      do_reset();
      q = {8'hA5, 8'h12};
      drain("tmo");
      t0 = last_acc_tick;
      while (tick_n < t0 + TimeoutCyc - 1) tick();
      n_checks++;
      if (err_cnt !== 8'h00) begin n_fail++; $display("FAIL tmo_early: got %h want 00", err_cnt); end
      repeat (2) tick();
      n_checks++;
      if (err_cnt !== 8'h01) begin n_fail++; $display("FAIL tmo_err: got %h want 01", err_cnt); end
      q = {8'hA5, 8'h12, 8'h34, 8'h56, 8'h70};
      drain("tmo_next");
      n_checks++; if (wr_cnt != 1) begin n_fail++; $display("FAIL tmo_next_wr: got %0d want 1", wr_cnt); end
      n_checks++;
      if (wr_addr !== 8'h12 || wr_data !== 16'h3456) begin
         n_fail++; $display("FAIL tmo_next_frame: got %h/%h want 12/3456", wr_addr, wr_data);
      end
      n_checks++;
      if (err_cnt !== 8'h01) begin n_fail++; $display("FAIL tmo_once: got %h want 01", err_cnt); end
   endtask

   // Next byte lands on exactly the edge where the idle count hits TimeoutCyc.
   task automatic test_byte_beats_timeout();
      int t0;
      do_reset();
      q = {8'hA5};
      drain("race");
      t0 = last_acc_tick;
      while (tick_n < t0 + TimeoutCyc - 3) tick();
      q = {8'h12};
      repeat (3) tick();
      n_checks++;
      if (last_acc_tick != t0 + TimeoutCyc) begin
         n_fail++; $display("FAIL race_edge: got %0d want %0d", last_acc_tick - t0, TimeoutCyc);
      end
      q = {8'h34, 8'h56, 8'h70};
      drain("race_rest");
      n_checks++;
      if (err_cnt !== 8'h00) begin n_fail++; $display("FAIL race_err: got %h want 00", err_cnt); end
      n_checks++;
      if (drop_cnt !== 8'h00) begin n_fail++; $display("FAIL race_drop: got %h want 00", drop_cnt); end
      n_checks++;
      if (wr_cnt != 1 || wr_addr !== 8'h12) begin
         n_fail++; $display("FAIL race_wr: got %0d/%h want 1/12", wr_cnt, wr_addr);
      end
   endtask

   task automatic test_en_drop();
      do_reset();
      q = {8'hA5};
      tick();
      n_checks++;
      if (oe_n !== 1'b0 || rd_n !== 1'b1) begin
         n_fail++; $display("FAIL oewait_bus: got oe=%b rd=%b want 0/1", oe_n, rd_n);
      end
      rx_en = 1'b0;
      tick();
      n_checks++;
      if (oe_n !== 1'b1 || rd_n !== 1'b1 || busy !== 1'b0) begin
         n_fail++; $display("FAIL oewait_drop: got oe=%b rd=%b busy=%b want 1/1/0", oe_n, rd_n, busy);
      end
      do_reset();
      q = {8'hA5, 8'h12, 8'h34, 8'h56, 8'h70};
      for (int i = 0; i < 20 && acc_cnt < 2; i++) tick();
      rx_en = 1'b0;
      tick();
      n_checks++;
      if (oe_n !== 1'b1 || rd_n !== 1'b1) begin
         n_fail++; $display("FAIL endrop_bus: got oe=%b rd=%b want 1/1", oe_n, rd_n);
      end
      repeat (10) tick();
      n_checks++;
      if (wr_cnt != 0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL endrop_hold: got wr=%0d busy=%b want 0/0", wr_cnt, busy);
      end
      rx_en = 1'b1;
      drain("endrop");
      n_checks++;
      if (wr_cnt != 1 || wr_addr !== 8'h12 || wr_data !== 16'h3456) begin
         n_fail++;
         $display("FAIL endrop_resume: got %0d %h/%h want 1 12/3456", wr_cnt, wr_addr, wr_data);
      end
   endtask

   task automatic test_reset_mid_frame();
      do_reset();
      q = {8'hA5, 8'h12, 8'h34, 8'h56, 8'h70};
      drain("rstmid_pre");
      q = {8'h00, 8'hA5, 8'h12, 8'h34};
      for (int i = 0; i < 20 && acc_cnt < 8; i++) tick();
      n_checks++;
      if (drop_cnt !== 8'h01) begin n_fail++; $display("FAIL rstmid_pre: got %h want 01", drop_cnt); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++;
      if (oe_n !== 1'b1 || rd_n !== 1'b1 || busy !== 1'b0) begin
         n_fail++; $display("FAIL rstmid_bus: got oe=%b rd=%b busy=%b want 1/1/0", oe_n, rd_n, busy);
      end
      n_checks++;
      if (drop_cnt !== 8'h00 || err_cnt !== 8'h00) begin
         n_fail++; $display("FAIL rstmid_cnt: got drop=%h err=%h want 00/00", drop_cnt, err_cnt);
      end
      n_checks++;
      if (reg_addr !== 8'h00 || reg_data !== 16'h0) begin
         n_fail++; $display("FAIL rstmid_reg: got %h/%h want 00/0000", reg_addr, reg_data);
      end
      wr_cnt = 0;
      drain("rstmid_post");
      n_checks++;
      if (drop_cnt !== 8'h01 || wr_cnt != 0) begin
         n_fail++; $display("FAIL rstmid_discard: got drop=%h wr=%0d want 01/0", drop_cnt, wr_cnt);
      end
   endtask

   task automatic test_saturate();
      do_reset();
      for (int i = 0; i < 300; i++) q.push_back(8'h00);
      drain("sat");
      n_checks++;
      if (drop_cnt !== 8'hFF) begin n_fail++; $display("FAIL sat_drop: got %h want ff", drop_cnt); end
   endtask

   initial begin
      rst   = 1'b1;
      rx_en = 1'b0;
      rxf   = 1'b1;
      adbus = 8'h00;
      test_reset();
      test_valid_frame();
      test_bad_csum();
      test_hunt();
      test_split_burst();
      test_timeout();
      test_byte_beats_timeout();
      test_en_drop();
      test_reset_mid_frame();
      test_saturate();
      n_checks++;
      if (rd_viol != 0) begin n_fail++; $display("FAIL rd_hold: got %0d bad cycles want 0", rd_viol); end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
